fp_cvt_seq: RTL and testbench
=============================

// Module: fp_cvt_seq
// PURPOSE
//  Sequencer for the combinational float/int conversion datapath and the shared rounder.
//  Accepts conversion requests (f2f, f2i, i2f) over valid/ready and drives the cvt unit from stage S1.
//  Routes f2f/i2f through the rounder in S2; f2i bypasses the rounder.
//  Returns results in order with tag, backpressure and flush.
// PARAMETERS
//  TAG_W  4  width of request/response tag
// PORTS
//  reset       in   1       synchronous, active-low
//  clock       in   1       single clock, rising edge
//  flush       in   1       drop all in-flight ops
//  req_valid   in   1       request offered
//  req_ready   out  1       request accepted when req_valid&req_ready
//  req_kind    in   2       0=f2f 1=f2i 2=i2f 3=illegal
//  req_data    in   65      operand (ext-float {sign,exp12,mant52} or integer in [63:0])
//  req_op      in   2       fcvt_op (0=w 1=wu 2=l 3=lu)
//  req_fmt     in   2       target/source fp format (0=single 1=double)
//  req_rm      in   3       rounding mode
//  req_class   in   10      classification of req_data
//  req_tag     in   TAG_W   opaque id, returned with result
//  cvt_f2f_i   out  struct  fp_cvt_f2f_in_type, from S1
//  cvt_f2f_o   in   struct  fp_cvt_f2f_out_type
//  cvt_f2i_i   out  struct  fp_cvt_f2i_in_type, from S1
//  cvt_f2i_o   in   struct  fp_cvt_f2i_out_type
//  cvt_i2f_i   out  struct  fp_cvt_i2f_in_type, from S1
//  cvt_i2f_o   in   struct  fp_cvt_i2f_out_type
//  rnd_i       out  struct  fp_rnd_in_type, from S2
//  rnd_o       in   struct  fp_rnd_out_type (result 64, flags 5)
//  rsp_valid   out  1       result available
//  rsp_ready   in   1       result consumed when rsp_valid&rsp_ready
//  rsp_result  out  64      converted value
//  rsp_flags   out  5       {NV,DZ,OF,UF,NX}
//  rsp_tag     out  TAG_W   tag of returned op
//  busy        out  1       s1_valid|s2_valid
// BEHAVIOUR
//  Reset (reset==0 at posedge): s1_valid=s2_valid=0; rsp_valid=0, busy=0, rsp_result=0, rsp_flags=0, rsp_tag=0.
//  Reset mid-operation discards all in-flight ops; no response is produced for them.
//  Pipeline: adv2 = s2_valid & rsp_ready, or !s2_valid.
//   adv1 = adv2 | !s1_valid.
//   req_ready = adv1 & !flush.
//  S1 captures {kind,data,op,fmt,rm,class,tag} on accept; only the selected cvt input is driven, others held 0.
//  S1->S2 at adv1 (when s1_valid):
//   f2f captures cvt_f2f_o.fp_rnd; i2f captures cvt_i2f_o.fp_rnd; f2i captures result/flags.
//   kind 3 captures result=0, flags=5'b10000.
//  S2 output: rsp_result/flags = rnd_o for f2f/i2f, the captured values otherwise.
//   rnd_i is zero unless s2 holds f2f/i2f.
//  Latency: accept at edge N -> rsp_valid from edge N+2. Throughput 1/cycle; capacity 2 ops.
//  rsp_* stable while rsp_valid & !rsp_ready. Strict in-order return.
//  flush: at the next edge s1_valid=s2_valid=0; a request in the flush cycle is not accepted (req_ready=0).
//   flush takes priority over rsp_ready in the same cycle; that response counts as not delivered.
// CONFIGURATION
//  FP_CVT_SEQ_BYPASS_EN defined:
//   if !s2_valid and S1 holds f2i/kind3, rsp_* presents S1 directly: latency 1.
//   On handshake, S1 retires without entering S2; order still holds because S2 is empty.
//  Not defined: every op takes 2 cycles through S2.
// STRUCTURE
//  fp_wire gains fp_cvt_kind_t (F2F,F2I,I2F,ILL), fp_cvt_seq_s1_type and fp_cvt_seq_s2_type, and constant FP_CVT_NV_FLAG=5'b10000.
//  One sub-module: fp_cvt_seq_slice, a payload register with valid, load/clear; instantiated for S1 and S2.
// TESTING
//  f2i op=3, class[7]=1 (+inf), rsp_ready=1 -> rsp at N+2: result 64'hFFFF_FFFF_FFFF_FFFF, flags 5'b10000.
//  4 back-to-back i2f (data 1,2,3,4; tags 0..3), rsp_ready=1 -> 4 consecutive rsp cycles from N+2, tags 0,1,2,3, rnd_i driven each.
//  rsp_ready=0 for 5 cycles, 3 requests offered -> 2 accepted, req_ready=0 thereafter, rsp_tag/result stable; release -> third accepted, order kept.
//  Both stages full, flush=1 with req_valid=1 -> next cycle rsp_valid=0, busy=0, request not accepted.
//  kind=3, tag=5 -> result 0, flags 5'b10000, tag 5 at N+2; reset low mid-stream -> all outputs 0 next cycle.
//  BYPASS_EN: f2i on idle pipe -> rsp_valid at N+1; f2i then i2f back-to-back -> responses in request order.

Source files
------------

// File: rtl/fp_cvt_seq_pkg.sv
// Shared types for the conversion sequencer: op kinds, converter/rounder
// interface structs and the per-stage payloads.
package fp_cvt_seq_pkg;

    typedef enum logic [1:0] {
        F2F = 2'd0,
        F2I = 2'd1,
        I2F = 2'd2,
        ILL = 2'd3
    } fp_cvt_kind_t;

    localparam logic [4:0] FP_CVT_NV_FLAG = 5'b10000;

    typedef struct packed {
        logic        sig;
        logic [13:0] expo;
        logic [53:0] mant;
        logic [1:0]  rema;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic [2:0]  grs;
        logic        snan;
        logic        qnan;
        logic        dbz;
        logic        infs;
        logic        zero;
        logic        diff;
    } fp_rnd_in_type;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  flags;
    } fp_rnd_out_type;

    typedef struct packed {
        logic [64:0] data;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic [9:0]  classification;
    } fp_cvt_f2f_in_type;

    typedef struct packed {
        fp_rnd_in_type fp_rnd;
    } fp_cvt_f2f_out_type;

    typedef struct packed {
        logic [64:0] data;
        logic [1:0]  op;
        logic [2:0]  rm;
        logic [9:0]  classification;
    } fp_cvt_f2i_in_type;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  flags;
    } fp_cvt_f2i_out_type;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  op;
        logic [1:0]  fmt;
        logic [2:0]  rm;
    } fp_cvt_i2f_in_type;

    typedef struct packed {
        fp_rnd_in_type fp_rnd;
    } fp_cvt_i2f_out_type;

    typedef struct packed {
        fp_cvt_kind_t kind;
        logic [64:0]  data;
        logic [1:0]   op;
        logic [1:0]   fmt;
        logic [2:0]   rm;
        logic [9:0]   classification;
    } fp_cvt_seq_s1_type;

    typedef struct packed {
        fp_cvt_kind_t  kind;
        fp_rnd_in_type fp_rnd;
        logic [63:0]   result;
        logic [4:0]    flags;
    } fp_cvt_seq_s2_type;

    function automatic logic uses_rnd(input fp_cvt_kind_t kind);
        return (kind == F2F) || (kind == I2F);
    endfunction

endpackage

// File: rtl/fp_cvt_seq_slice.sv
// One pipeline stage: a payload register plus its valid bit, with clear
// taking priority over load.
module fp_cvt_seq_slice #(
    parameter type payload_t = logic [0:0]
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     clear,
    input  logic     load,
    input  payload_t d,
    output logic     valid,
    output payload_t q
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // NOTE: the payload is deliberately not reset; every consumer gates it with valid.
    always_ff @(posedge clock) begin
        if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fp_cvt_seq.sv
// Two-stage in-order sequencer for the float/int converter and shared rounder.
// Optional macro FP_CVT_SEQ_BYPASS_EN: f2i/illegal ops return straight from S1 when S2 is empty.
module fp_cvt_seq
    import fp_cvt_seq_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_kind,
    input  logic [64:0]        req_data,
    input  logic [1:0]         req_op,
    input  logic [1:0]         req_fmt,
    input  logic [2:0]         req_rm,
    input  logic [9:0]         req_class,
    input  logic [TAG_W-1:0]   req_tag,
    output fp_cvt_f2f_in_type  cvt_f2f_i,
    input  fp_cvt_f2f_out_type cvt_f2f_o,
    output fp_cvt_f2i_in_type  cvt_f2i_i,
    input  fp_cvt_f2i_out_type cvt_f2i_o,
    output fp_cvt_i2f_in_type  cvt_i2f_i,
    input  fp_cvt_i2f_out_type cvt_i2f_o,
    output fp_rnd_in_type      rnd_i,
    input  fp_rnd_out_type     rnd_o,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [63:0]        rsp_result,
    output logic [4:0]         rsp_flags,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic               busy
);

    typedef struct packed {
        fp_cvt_seq_s1_type  p;
        logic [TAG_W-1:0]   tag;
    } s1_slot_t;

    typedef struct packed {
        fp_cvt_seq_s2_type  p;
        logic [TAG_W-1:0]   tag;
    } s2_slot_t;

    s1_slot_t s1_d, s1_q;
    s2_slot_t s2_d, s2_q;
    logic     s1_valid, s2_valid;
    logic     adv1, adv2, accept;
    logic     bypass, bypass_fire, s2_load;

`ifdef FP_CVT_SEQ_BYPASS_EN
    assign bypass = s1_valid && !s2_valid && (s1_q.p.kind == F2I || s1_q.p.kind == ILL);
`else
    assign bypass = 1'b0;
`endif

    assign adv2        = (s2_valid && rsp_ready) || !s2_valid;
    assign adv1        = adv2 || !s1_valid;
    assign req_ready   = adv1 && !flush;
    assign accept      = req_valid && req_ready;
    // A bypassed op that handshakes retires from S1 and never occupies S2.
    assign bypass_fire = bypass && rsp_ready && !flush;
    assign s2_load     = adv1 && s1_valid && !flush && !bypass_fire;
    assign busy        = s1_valid || s2_valid;

    always_comb begin
        s1_d                  = '0;
        s1_d.p.kind           = fp_cvt_kind_t'(req_kind);
        s1_d.p.data           = req_data;
        s1_d.p.op             = req_op;
        s1_d.p.fmt            = req_fmt;
        s1_d.p.rm             = req_rm;
        s1_d.p.classification = req_class;
        s1_d.tag              = req_tag;
    end

    fp_cvt_seq_slice #(.payload_t(s1_slot_t)) u_s1 (
        .clock (clock),
        .reset (reset),
        .clear (flush || (adv1 && !accept)),
        .load  (accept),
        .d     (s1_d),
        .valid (s1_valid),
        .q     (s1_q)
    );

    // Only the converter that matches the S1 op sees a non-zero input.
    always_comb begin
        cvt_f2f_i = '0;
        cvt_f2i_i = '0;
        cvt_i2f_i = '0;
        if (s1_valid) begin
            case (s1_q.p.kind)
                F2F: begin
                    cvt_f2f_i.data           = s1_q.p.data;
                    cvt_f2f_i.fmt            = s1_q.p.fmt;
                    cvt_f2f_i.rm             = s1_q.p.rm;
                    cvt_f2f_i.classification = s1_q.p.classification;
                end
                F2I: begin
                    cvt_f2i_i.data           = s1_q.p.data;
                    cvt_f2i_i.op             = s1_q.p.op;
                    cvt_f2i_i.rm             = s1_q.p.rm;
                    cvt_f2i_i.classification = s1_q.p.classification;
                end
                I2F: begin
                    cvt_i2f_i.data = s1_q.p.data[63:0];
                    cvt_i2f_i.op   = s1_q.p.op;
                    cvt_i2f_i.fmt  = s1_q.p.fmt;
                    cvt_i2f_i.rm   = s1_q.p.rm;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s2_d        = '0;
        s2_d.p.kind = s1_q.p.kind;
        s2_d.tag    = s1_q.tag;
        case (s1_q.p.kind)
            F2F:     s2_d.p.fp_rnd = cvt_f2f_o.fp_rnd;
            I2F:     s2_d.p.fp_rnd = cvt_i2f_o.fp_rnd;
            F2I: begin
                s2_d.p.result = cvt_f2i_o.result;
                s2_d.p.flags  = cvt_f2i_o.flags;
            end
            default: s2_d.p.flags = FP_CVT_NV_FLAG;
        endcase
    end

    fp_cvt_seq_slice #(.payload_t(s2_slot_t)) u_s2 (
        .clock (clock),
        .reset (reset),
        .clear (flush || (adv2 && !s2_load)),
        .load  (s2_load),
        .d     (s2_d),
        .valid (s2_valid),
        .q     (s2_q)
    );

    always_comb begin
        rnd_i      = '0;
        rsp_valid  = 1'b0;
        rsp_result = '0;
        rsp_flags  = '0;
        rsp_tag    = '0;
        if (s2_valid) begin
            rsp_valid = 1'b1;
            rsp_tag   = s2_q.tag;
            if (uses_rnd(s2_q.p.kind)) begin
                rnd_i      = s2_q.p.fp_rnd;
                rsp_result = rnd_o.result;
                rsp_flags  = rnd_o.flags;
            end else begin
                rsp_result = s2_q.p.result;
                rsp_flags  = s2_q.p.flags;
            end
        end else if (bypass) begin
            rsp_valid  = 1'b1;
            rsp_tag    = s1_q.tag;
            rsp_result = s2_d.p.result;
            rsp_flags  = s2_d.p.flags;
        end
    end

endmodule

// File: tb/tb_fp_cvt_seq.sv
// Self-checking bench for fp_cvt_seq: stand-in converter/rounder units, a
// request-level reference model with an in-order scoreboard, directed and random traffic.
module tb_fp_cvt_seq;
    import fp_cvt_seq_pkg::*;

    localparam int TAG_W = 4;

    typedef struct packed {
        logic [1:0]       kind;
        logic [64:0]      data;
        logic [1:0]       op;
        logic [1:0]       fmt;
        logic [2:0]       rm;
        logic [9:0]       cls;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef struct packed {
        logic [63:0]      result;
        logic [4:0]       flags;
        logic [TAG_W-1:0] tag;
    } exp_t;

    typedef struct packed {
        req_t        q;
        logic [63:0] result;
        logic [4:0]  flags;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    logic req_valid = 1'b0;
    logic rsp_ready = 1'b0;
    req_t cur = '0;

    logic               req_ready, rsp_valid, busy;
    logic [63:0]        rsp_result;
    logic [4:0]         rsp_flags;
    logic [TAG_W-1:0]   rsp_tag;
    fp_cvt_f2f_in_type  cvt_f2f_i;
    fp_cvt_f2f_out_type cvt_f2f_o;
    fp_cvt_f2i_in_type  cvt_f2i_i;
    fp_cvt_f2i_out_type cvt_f2i_o;
    fp_cvt_i2f_in_type  cvt_i2f_i;
    fp_cvt_i2f_out_type cvt_i2f_o;
    fp_rnd_in_type      rnd_i;
    fp_rnd_out_type     rnd_o;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    fp_cvt_seq #(.TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(cur.kind), .req_data(cur.data), .req_op(cur.op),
        .req_fmt(cur.fmt), .req_rm(cur.rm), .req_class(cur.cls), .req_tag(cur.tag),
        .cvt_f2f_i(cvt_f2f_i), .cvt_f2f_o(cvt_f2f_o),
        .cvt_f2i_i(cvt_f2i_i), .cvt_f2i_o(cvt_f2i_o),
        .cvt_i2f_i(cvt_i2f_i), .cvt_i2f_o(cvt_i2f_o),
        .rnd_i(rnd_i), .rnd_o(rnd_o),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .busy(busy)
    );

    // Stand-in combinational units: arbitrary but information-preserving mappings.
    function automatic fp_rnd_in_type f2f_unit(input fp_cvt_f2f_in_type i);
        fp_rnd_in_type r;
        r      = '0;
        r.sig  = i.data[64];
        r.expo = {2'b00, i.data[63:52]};
        r.mant = {i.data[51:0], 2'b01};
        r.fmt  = i.fmt;
        r.rm   = i.rm;
        r.grs  = i.classification[2:0];
        r.zero = i.classification[3];
        r.dbz  = ^i.classification[6:4];
        r.infs = i.classification[7];
        r.snan = i.classification[8];
        r.qnan = i.classification[9];
        return r;
    endfunction

    function automatic fp_rnd_in_type i2f_unit(input fp_cvt_i2f_in_type i);
        fp_rnd_in_type r;
        r      = '0;
        r.sig  = i.data[63] & ~i.op[0];
        r.expo = {6'd0, i.data[62:57], i.fmt};
        r.mant = i.data[53:0];
        r.rema = i.op;
        r.rm   = i.rm;
        r.grs  = i.data[56:54];
        r.diff = 1'b1;
        return r;
    endfunction

    function automatic fp_rnd_out_type rnd_unit(input fp_rnd_in_type r);
        fp_rnd_out_type o;
        o.result = {r.sig, r.expo[12:0], r.mant[49:0]} ^ {59'd0, r.rema, r.rm};
        o.flags  = {r.grs ^ {r.snan, r.qnan, r.dbz}, r.zero ^ r.infs ^ r.expo[13],
                    r.diff ^ (^r.mant[53:50])};
        return o;
    endfunction

    function automatic fp_cvt_f2i_out_type f2i_unit(input fp_cvt_f2i_in_type i);
        fp_cvt_f2i_out_type o;
        o = '0;
        if (i.classification[7]) begin
            case (i.op)
                2'd0:    o.result = 64'h0000_0000_7FFF_FFFF;
                2'd2:    o.result = 64'h7FFF_FFFF_FFFF_FFFF;
                default: o.result = 64'hFFFF_FFFF_FFFF_FFFF;
            endcase
            o.flags = 5'b10000;
        end else begin
            o.result = i.data[63:0] ^ {i.data[64], 58'd0, i.rm, i.op} ^ {54'd0, i.classification};
            o.flags  = {4'd0, |i.data[3:0]};
        end
        return o;
    endfunction

    always_comb cvt_f2f_o.fp_rnd = f2f_unit(cvt_f2f_i);
    always_comb cvt_i2f_o.fp_rnd = i2f_unit(cvt_i2f_i);
    always_comb cvt_f2i_o = f2i_unit(cvt_f2i_i);
    always_comb rnd_o = rnd_unit(rnd_i);

    // Reference: what the whole request should produce, independent of pipeline timing.
    function automatic exp_t model(input req_t q);
        fp_cvt_f2f_in_type  a;
        fp_cvt_f2i_in_type  b;
        fp_cvt_i2f_in_type  c;
        fp_rnd_out_type     ro;
        fp_cvt_f2i_out_type io;
        exp_t               m;
        a = '{data: q.data, fmt: q.fmt, rm: q.rm, classification: q.cls};
        b = '{data: q.data, op: q.op, rm: q.rm, classification: q.cls};
        c = '{data: q.data[63:0], op: q.op, fmt: q.fmt, rm: q.rm};
        m.tag = q.tag;
        case (q.kind)
            2'd0: begin ro = rnd_unit(f2f_unit(a)); m.result = ro.result; m.flags = ro.flags; end
            2'd1: begin io = f2i_unit(b); m.result = io.result; m.flags = io.flags; end
            2'd2: begin ro = rnd_unit(i2f_unit(c)); m.result = ro.result; m.flags = ro.flags; end
            default: begin m.result = 64'd0; m.flags = 5'b10000; end
        endcase
        return m;
    endfunction

    function automatic int exp_lat(input logic [1:0] kind);
`ifdef FP_CVT_SEQ_BYPASS_EN
        return (kind == 2'd1 || kind == 2'd3) ? 1 : 2;
`else
        return (kind == 2'd1 || kind == 2'd3) ? 2 : 2;
`endif
    endfunction

    function automatic req_t mk(input logic [1:0] kind, input logic [64:0] data,
                                input logic [1:0] op, input logic [9:0] cls,
                                input logic [TAG_W-1:0] tag);
        req_t r;
        r = '{kind: kind, data: data, op: op, fmt: 2'd1, rm: 3'd1, cls: cls, tag: tag};
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock: settle, score handshakes, cross the edge, land 1 time unit after it.
    task automatic tick(output logic acc);
        logic drop;
        exp_t e;
        #1;
        acc  = reset && req_valid && req_ready;
        drop = flush || !reset;
        if (acc) sb.push_back(model(cur));
        if (reset && !flush && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got tag %0h with nothing outstanding", rsp_tag);
            end else begin
                e = sb.pop_front();
                check("rsp_result", rsp_result, e.result);
                check("rsp_flags", rsp_flags, e.flags);
                check("rsp_tag", rsp_tag, e.tag);
            end
        end
        @(posedge clock);
        #1;
        if (drop) sb.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t             vecs[6];
        logic             a;
        int               lat, seen, first, last, n;
        logic [63:0]      hold_result;
        logic [TAG_W-1:0] hold_tag;
        logic             held;
        fp_cvt_i2f_in_type ii;

        repeat (2) @(posedge clock);
        #1;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_rsp_result", rsp_result, 0);
        check("reset_rsp_flags", rsp_flags, 0);
        check("reset_rsp_tag", rsp_tag, 0);
        reset = 1'b1;
        #1;
        check("idle_req_ready", req_ready, 1);

        vecs[0] = '{q: mk(2'd1, 65'h0, 2'd3, 10'h080, 4'd1), result: 64'hFFFF_FFFF_FFFF_FFFF, flags: 5'b10000};
        vecs[1] = '{q: mk(2'd3, 65'h1_2345_6789_ABCD_EF01, 2'd0, 10'h0, 4'd5), result: 64'd0, flags: 5'b10000};
        vecs[2] = '{q: mk(2'd1, 65'hA5, 2'd2, 10'h0, 4'd2), result: 64'hA3, flags: 5'b00001};
        vecs[3] = '{q: mk(2'd1, 65'h0, 2'd0, 10'h080, 4'd3), result: 64'h0000_0000_7FFF_FFFF, flags: 5'b10000};
        vecs[4] = '{q: mk(2'd0, 65'h1_4009_21FB_5444_2D18, 2'd0, 10'h045, 4'd4), result: 64'd0, flags: 5'd0};
        vecs[5] = '{q: mk(2'd2, 65'h0_8000_0000_0000_1234, 2'd2, 10'h0, 4'd6), result: 64'd0, flags: 5'd0};
        for (int i = 4; i < 6; i++) begin
            vecs[i].result = model(vecs[i].q).result;
            vecs[i].flags  = model(vecs[i].q).flags;
        end

        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cur = vecs[i].q;
            req_valid = 1'b1;
            tick(a);
            check("vec_accept", a, 1);
            req_valid = 1'b0;
            lat = 1;
            while (!rsp_valid && lat < 8) begin
                tick(a);
                lat++;
            end
            check("vec_latency", lat, exp_lat(vecs[i].q.kind));
            check("vec_result", rsp_result, vecs[i].result);
            check("vec_flags", rsp_flags, vecs[i].flags);
            check("vec_tag", rsp_tag, vecs[i].q.tag);
            tick(a);
        end

        // Four back-to-back i2f requests stream out on consecutive cycles.
        seen = 0; first = -1; last = -1;
        for (int k = 0; k < 9; k++) begin
            req_valid = (k < 4);
            cur = mk(2'd2, 65'(k + 1), 2'd2, 10'h0, 4'(k));
            if (rsp_valid) begin
                ii = '{data: 64'(seen + 1), op: 2'd2, fmt: 2'd1, rm: 3'd1};
                check("b2b_tag", rsp_tag, seen);
                check("b2b_rnd_i", rnd_i, i2f_unit(ii));
                if (first < 0) first = k;
                last = k;
                seen++;
            end
            tick(a);
        end
        req_valid = 1'b0;
        check("b2b_count", seen, 4);
        check("b2b_first_cycle", first, 2);
        check("b2b_contiguous", last - first, 3);

        // Backpressure: only two ops fit, outputs hold while stalled.
        rsp_ready = 1'b0; n = 0; held = 1'b0; hold_result = '0; hold_tag = '0;
        for (int k = 0; k < 5; k++) begin
            req_valid = (n < 3);
            cur = mk(2'd2, 65'(100 + n), 2'd2, 10'h0, 4'(8 + n));
            if (rsp_valid) begin
                if (held) begin
                    check("stall_tag_stable", rsp_tag, hold_tag);
                    check("stall_result_stable", rsp_result, hold_result);
                end
                held = 1'b1;
                hold_tag = rsp_tag;
                hold_result = rsp_result;
            end
            tick(a);
            if (a) n++;
        end
        check("stall_accepted", n, 2);
        check("stall_req_ready", req_ready, 0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 10 && (n < 3 || sb.size() != 0); k++) begin
            req_valid = (n < 3);
            tick(a);
            if (a) n++;
        end
        req_valid = 1'b0;
        check("stall_third_accepted", n, 3);
        check("stall_drained", sb.size(), 0);

        // Flush with both stages full and a request on offer.
        rsp_ready = 1'b0; n = 0;
        for (int k = 0; k < 6 && n < 2; k++) begin
            req_valid = 1'b1;
            cur = mk(2'd2, 65'(200 + n), 2'd2, 10'h0, 4'(12 + n));
            tick(a);
            if (a) n++;
        end
        check("flush_prefill", n, 2);
        check("flush_full_busy", busy, 1);
        check("flush_full_rsp_valid", rsp_valid, 1);
        flush = 1'b1;
        req_valid = 1'b1;
        cur = mk(2'd1, 65'h77, 2'd0, 10'h0, 4'd3);
        #1;
        check("flush_req_ready", req_ready, 0);
        tick(a);
        check("flush_no_accept", a, 0);
        flush = 1'b0;
        req_valid = 1'b0;
        check("flush_rsp_valid", rsp_valid, 0);
        check("flush_busy", busy, 0);
        tick(a);
        check("flush_still_idle", busy, 0);

        // Reset in the middle of traffic discards everything.
        n = 0;
        for (int k = 0; k < 6 && n < 2; k++) begin
            req_valid = 1'b1;
            cur = mk(2'd3, 65'h5, 2'd0, 10'h0, 4'(5 + n));
            tick(a);
            if (a) n++;
        end
        req_valid = 1'b0;
        reset = 1'b0;
        tick(a);
        check("midreset_rsp_valid", rsp_valid, 0);
        check("midreset_busy", busy, 0);
        check("midreset_rsp_result", rsp_result, 0);
        check("midreset_rsp_flags", rsp_flags, 0);
        check("midreset_rsp_tag", rsp_tag, 0);
        reset = 1'b1;
        tick(a);
        check("postreset_busy", busy, 0);

        // f2i followed directly by i2f: responses keep request order.
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        cur = mk(2'd1, 65'h1234, 2'd1, 10'h0, 4'd1);
        tick(a);
        cur = mk(2'd2, 65'h5678, 2'd3, 10'h0, 4'd2);
        tick(a);
        req_valid = 1'b0;
        for (int k = 0; k < 6 && sb.size() != 0; k++) tick(a);
        check("order_drained", sb.size(), 0);

        // Random traffic against the scoreboard.
        for (int k = 0; k < 1500; k++) begin
            req_valid = ($urandom_range(0, 9) < 7);
            rsp_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 63) == 0);
            cur.kind  = 2'($urandom_range(0, 3));
            cur.data  = {1'($urandom), $urandom, $urandom};
            cur.op    = 2'($urandom);
            cur.fmt   = 2'($urandom_range(0, 1));
            cur.rm    = 3'($urandom);
            cur.cls   = ($urandom_range(0, 3) == 0) ? 10'h080 : 10'($urandom);
            cur.tag   = 4'($urandom);
            tick(a);
        end
        flush = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 10 && (sb.size() != 0 || busy); k++) tick(a);
        check("random_drained", sb.size(), 0);
        check("random_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
